// File: rtl/mips_control_unit_if.sv
// Control-unit bus: instruction and zero flag in, datapath controls out.
// master = instruction source / datapath, slave = control unit.
interface mips_control_unit_if;
  logic [31:0] Instruction;
  logic        Zero;
  logic        RegDst;
  logic [1:0]  ALUOp;
  logic        ALUZero;
  logic        ALUSrc;
  logic        Branch;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegWrite;
  logic        PCSrc;
  logic [5:0]  ALUControl;
  logic        Debug;

  modport master (
    output Instruction, Zero,
    input  RegDst, ALUOp, ALUZero, ALUSrc,
    input  Branch, MemRead, MemWrite,
    input  MemtoReg, RegWrite, PCSrc,
    input  ALUControl, Debug
  );

  modport slave (
    input  Instruction, Zero,
    output RegDst, ALUOp, ALUZero, ALUSrc,
    output Branch, MemRead, MemWrite,
    output MemtoReg, RegWrite, PCSrc,
    output ALUControl, Debug
  );
endinterface

// File: rtl/mips_control_unit.sv
// MIPS main control: registered decode, ALU function code, branch select.
// Ports: Clk, Rst (async active-low), bus (slave side of control bus).
module mips_control_unit (
  input  logic Clk,
  input  logic Rst,
  mips_control_unit_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_zero;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       debug;
    logic [5:0] opcode;
    logic [5:0] funct;
  } ctrl_t;

  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;
  logic [5:0] op;
  logic [5:0] alu_ctrl;
  logic       is_bne;
  logic       unused_instr;

  assign op           = bus.Instruction[31:26];
  assign unused_instr = ^bus.Instruction[25:6];

  always_comb begin
    ctrl_d        = '0;
    ctrl_d.opcode = op;
    ctrl_d.funct  = bus.Instruction[5:0];
    unique case (1'b1)
      (op == OP_RTYPE): begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = 2'b00;
      end
      (op == OP_ADDI || op == OP_SLTI): begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = 2'b01;
      end
      (op == OP_ANDI || op == OP_ORI ||
       op == OP_XORI): begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_zero  = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = 2'b01;
      end
      (op == OP_LW): begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_op     = 2'b01;
      end
      (op == OP_SW): begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_op    = 2'b01;
      end
      (op == OP_BEQ || op == OP_BNE): begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = 2'b10;
      end
      default: begin
        // unsupported opcode: flag it, datapath sees a NOP
        ctrl_d.debug = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  always_comb begin
    alu_ctrl = 6'b000000;
    unique case (ctrl_q.alu_op)
      2'b00: alu_ctrl = ctrl_q.funct;
      2'b01: begin
        unique case (1'b1)
          (ctrl_q.opcode == OP_ANDI): alu_ctrl = FN_AND;
          (ctrl_q.opcode == OP_ORI):  alu_ctrl = FN_OR;
          (ctrl_q.opcode == OP_XORI): alu_ctrl = FN_XOR;
          (ctrl_q.opcode == OP_SLTI): alu_ctrl = FN_SLT;
          default:                    alu_ctrl = FN_ADD;
        endcase
      end
      2'b10: alu_ctrl = FN_SUB;
      default: alu_ctrl = 6'b000000;
    endcase
  end

  // bne takes the branch on a non-zero compare; Zero is used live
  assign is_bne    = (ctrl_q.opcode == OP_BNE);
  assign bus.PCSrc = ctrl_q.branch & (bus.Zero ^ is_bne);

  assign bus.RegDst     = ctrl_q.reg_dst;
  assign bus.ALUOp      = ctrl_q.alu_op;
  assign bus.ALUZero    = ctrl_q.alu_zero;
  assign bus.ALUSrc     = ctrl_q.alu_src;
  assign bus.Branch     = ctrl_q.branch;
  assign bus.MemRead    = ctrl_q.mem_read;
  assign bus.MemWrite   = ctrl_q.mem_write;
  assign bus.MemtoReg   = ctrl_q.mem_to_reg;
  assign bus.RegWrite   = ctrl_q.reg_write;
  assign bus.Debug      = ctrl_q.debug;
  assign bus.ALUControl = alu_ctrl;

endmodule

// File: tb/tb_mips_control_unit.sv
// Bench for mips_control_unit: vector table, corner sequences, random.
// Output vector: {RegDst,ALUOp,ALUZero,ALUSrc,Branch,MR,MW,M2R,RW,Dbg,PCSrc,ALUCtl}
module tb_mips_control_unit;
  logic Clk;
  logic Rst;
  mips_control_unit_if bus();

  mips_control_unit dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total;
  int bad;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero;
    logic [17:0] exp;
  } vec_t;

  function automatic logic [17:0] mk(
    input logic rd, input logic [1:0] aop,
    input logic az, input logic as,
    input logic br, input logic mr,
    input logic mw, input logic m2r,
    input logic rw, input logic dbg,
    input logic pc, input logic [5:0] alc);
    return {rd, aop, az, as, br, mr, mw, m2r, rw, dbg, pc, alc};
  endfunction

  function automatic logic [17:0] got();
    return {bus.RegDst, bus.ALUOp, bus.ALUZero,
            bus.ALUSrc, bus.Branch, bus.MemRead,
            bus.MemWrite, bus.MemtoReg, bus.RegWrite,
            bus.Debug, bus.PCSrc, bus.ALUControl};
  endfunction

  // Reference: instruction class -> control bundle, by table of rules
  function automatic logic [17:0] model(
    input logic [31:0] ins, input logic z);
    logic [5:0] o;
    logic [5:0] f;
    o = ins[31:26];
    f = ins[5:0];
    case (o)
      6'h00: return mk(1,0,0,0,0,0,0,0,1,0,0,f);
      6'h08: return mk(0,1,0,1,0,0,0,0,1,0,0,6'h20);
      6'h0A: return mk(0,1,0,1,0,0,0,0,1,0,0,6'h2A);
      6'h0C: return mk(0,1,1,1,0,0,0,0,1,0,0,6'h24);
      6'h0D: return mk(0,1,1,1,0,0,0,0,1,0,0,6'h25);
      6'h0E: return mk(0,1,1,1,0,0,0,0,1,0,0,6'h26);
      6'h23: return mk(0,1,0,1,0,1,0,1,1,0,0,6'h20);
      6'h2B: return mk(0,1,0,1,0,0,1,0,0,0,0,6'h20);
      6'h04: return mk(0,2,0,0,1,0,0,0,0,0,z,6'h22);
      6'h05: return mk(0,2,0,0,1,0,0,0,0,0,!z,6'h22);
      default: return mk(0,0,0,0,0,0,0,0,0,1,0,f);
    endcase
  endfunction

  task automatic check(input string nm, input logic [17:0] want);
    logic [17:0] g;
    g = got();
    total++;
    if (g !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, g, want);
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic z);
    @(negedge Clk);
    bus.Instruction = ins;
    bus.Zero = z;
    @(posedge Clk);
    #1;
  endtask

  vec_t vt[$];
  logic [31:0] last;
  logic [5:0] pool [12];

  initial begin
    total = 0;
    bad = 0;
    Rst = 1'b0;
    bus.Instruction = 32'h10220001;
    bus.Zero = 1'b1;

    vt.push_back('{"add",  32'h00221820, 1'b0,
      mk(1,0,0,0,0,0,0,0,1,0,0,6'h20)});
    vt.push_back('{"sub",  32'h00221822, 1'b0,
      mk(1,0,0,0,0,0,0,0,1,0,0,6'h22)});
    vt.push_back('{"slt",  32'h0022182A, 1'b1,
      mk(1,0,0,0,0,0,0,0,1,0,0,6'h2A)});
    vt.push_back('{"addi", 32'h20220008, 1'b0,
      mk(0,1,0,1,0,0,0,0,1,0,0,6'h20)});
    vt.push_back('{"slti", 32'h28220008, 1'b0,
      mk(0,1,0,1,0,0,0,0,1,0,0,6'h2A)});
    vt.push_back('{"andi", 32'h30220005, 1'b0,
      mk(0,1,1,1,0,0,0,0,1,0,0,6'h24)});
    vt.push_back('{"ori",  32'h34220005, 1'b0,
      mk(0,1,1,1,0,0,0,0,1,0,0,6'h25)});
    vt.push_back('{"xori", 32'h38220005, 1'b0,
      mk(0,1,1,1,0,0,0,0,1,0,0,6'h26)});
    vt.push_back('{"lw",   32'h8C220004, 1'b0,
      mk(0,1,0,1,0,1,0,1,1,0,0,6'h20)});
    vt.push_back('{"sw",   32'hAC220004, 1'b0,
      mk(0,1,0,1,0,0,1,0,0,0,0,6'h20)});
    vt.push_back('{"beq_z1", 32'h10220001, 1'b1,
      mk(0,2,0,0,1,0,0,0,0,0,1,6'h22)});
    vt.push_back('{"beq_z0", 32'h10220001, 1'b0,
      mk(0,2,0,0,1,0,0,0,0,0,0,6'h22)});
    vt.push_back('{"bne_z1", 32'h14220001, 1'b1,
      mk(0,2,0,0,1,0,0,0,0,0,0,6'h22)});
    vt.push_back('{"bne_z0", 32'h14220001, 1'b0,
      mk(0,2,0,0,1,0,0,0,0,0,1,6'h22)});
    vt.push_back('{"bad_op", 32'hFC000000, 1'b1,
      mk(0,0,0,0,0,0,0,0,0,1,0,6'h00)});
    vt.push_back('{"bad_fn", 32'hFC00002A, 1'b0,
      mk(0,0,0,0,0,0,0,0,0,1,0,6'h2A)});

    // reset held across edges: everything zero
    repeat (2) @(posedge Clk);
    #1;
    check("reset", 18'h0);

    @(negedge Clk);
    Rst = 1'b1;
    foreach (vt[i]) begin
      step(vt[i].instr, vt[i].zero);
      check(vt[i].name, vt[i].exp);
    end

    // Zero toggles within a cycle, no edge
    step(32'h10220001, 1'b1);
    check("beq_live1", mk(0,2,0,0,1,0,0,0,0,0,1,6'h22));
    bus.Zero = 1'b0;
    #1;
    check("beq_live0", mk(0,2,0,0,1,0,0,0,0,0,0,6'h22));
    step(32'h14220001, 1'b1);
    check("bne_live1", mk(0,2,0,0,1,0,0,0,0,0,0,6'h22));
    bus.Zero = 1'b0;
    #1;
    check("bne_live0", mk(0,2,0,0,1,0,0,0,0,0,1,6'h22));

    // instruction change between edges is ignored
    step(32'h8C220004, 1'b0);
    bus.Instruction = 32'hAC220004;
    #2;
    check("hold_lw", mk(0,1,0,1,0,1,0,1,1,0,0,6'h20));

    // async reset mid-cycle, then release latches current instr
    step(32'h00221820, 1'b1);
    #1;
    Rst = 1'b0;
    #1;
    check("async_rst", 18'h0);
    bus.Instruction = 32'h20220008;
    @(posedge Clk);
    #1;
    check("rst_hold", 18'h0);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    check("rst_release", mk(0,1,0,1,0,0,0,0,1,0,0,6'h20));

    // randomized against the model
    pool = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
             6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F, 6'h02};
    for (int n = 0; n < 300; n++) begin
      logic [31:0] r;
      logic z;
      r = $urandom;
      if ($urandom_range(0, 3) != 0)
        r[31:26] = pool[$urandom_range(0, 11)];
      z = 1'($urandom_range(0, 1));
      step(r, z);
      last = r;
      bus.Instruction = $urandom;
      check("rand", model(last, z));
      bus.Zero = ~z;
      #1;
      check("rand_z", model(last, ~z));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_control_unit.md
# mips_control_unit

Main control path of the single-issue MIPS datapath: decodes a 32-bit instruction into registered datapath control signals. Also generates the 6-bit ALU function code from the ALU-operation class plus funct/opcode fields, and resolves the branch-taken select (PCSrc) from Branch and the ALU Zero flag. Sits between instruction fetch and the register file/ALU/data memory.

## Interface
- No parameters.
- Clk  in  1  clock; all registers update on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Instruction  in  32  current instruction; opcode [31:26], funct [5:0].
- Zero  in  1  ALU zero flag from the current compare.
- RegDst  out  1  1 = write register is rd; 0 = write register is rt.
- ALUOp  out  2  ALU class: 00 R-type, 01 immediate/memory, 10 branch, 11 unused.
- ALUZero  out  1  1 = zero-extend the immediate (logical immediates); 0 = sign-extend.
- ALUSrc  out  1  1 = ALU operand B is the immediate.
- Branch  out  1  conditional-branch instruction.
- MemRead, MemWrite  out  1 each  data-memory strobes.
- MemtoReg  out  1  1 = write-back data comes from memory.
- RegWrite  out  1  register-file write enable.
- PCSrc  out  1  1 = take branch target.
- ALUControl  out  6  ALU function code.
- Debug  out  1  1 = the latched opcode is unsupported.

## Operation
- Combinational decode of Instruction feeds one register bank: RegDst, ALUOp, ALUZero, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite and Debug. The latched opcode and funct fields are stored in the same bank.
- Decode table, listing only the signals that are set to 1 (all others 0):
  - R-type (000000): RegDst, RegWrite; ALUOp=00.
  - addi (001000) and slti (001010): ALUSrc, RegWrite; ALUOp=01.
  - andi (001100), ori (001101), xori (001110): ALUSrc, ALUZero, RegWrite; ALUOp=01.
  - lw (100011): ALUSrc, MemRead, MemtoReg, RegWrite; ALUOp=01.
  - sw (101011): ALUSrc, MemWrite; ALUOp=01.
  - beq (000100) and bne (000101): Branch; ALUOp=10.
  - Any other opcode: Debug=1, every other control output 0, ALUOp=00. The instruction behaves as a NOP.
- ALUControl is combinational from the registered ALUOp, funct and opcode:
  - ALUOp=00: the funct value passes through unchanged (add 100000, sub 100010, and 100100, or 100101, slt 101010, and so on).
  - ALUOp=01, by opcode:
    - addi, lw, sw → 100000.
    - andi → 100100.
    - ori → 100101.
    - xori → 100110.
    - slti → 101010.
    - Any other opcode → 100000.
  - ALUOp=10 → 100010 (subtract for compare).
  - ALUOp=11 → 000000.
- PCSrc is combinational: Branch AND (Zero XOR bne_latched), where bne_latched is 1 when the latched opcode is 000101. The Zero input is used live, not registered.

## Timing
- Decode latency is 1 cycle. An Instruction stable before rising edge N appears on the control outputs after edge N.
- ALUControl and PCSrc add no latency on top of the registered signals. PCSrc also follows Zero within the same cycle.
- Rst low clears all registers immediately, independent of Clk. Effect on outputs:
  - All 1-bit outputs go to 0.
  - ALUOp goes to 00.
  - ALUControl goes to 000000, because the latched funct is 0.
  - PCSrc goes to 0.
- On Rst release, the first rising edge latches the current Instruction.
- If Rst is asserted mid-stream, the in-flight decode is discarded.
- Instruction changes between edges have no effect on the outputs. Only Zero changes propagate between edges, through PCSrc.

## Test plan
- Reset: hold Rst=0 with arbitrary Instruction and Zero=1. All outputs must be 0, including ALUControl=000000 and PCSrc=0.
- add, 0x00221820, then one edge: RegDst=1, ALUOp=00, ALUSrc=0, RegWrite=1, MemRead=0, MemWrite=0, ALUControl=100000.
- addi, 0x20220008: RegDst=0, ALUOp=01, ALUSrc=1, RegWrite=1, MemRead=0, MemWrite=0, ALUControl=100000.
- beq, 0x10220001, with Zero=1: RegDst=0, ALUOp=10, ALUSrc=0, Branch=1, PCSrc=1, ALUControl=100010. Then drop Zero to 0 with no edge: PCSrc=0 in the same cycle. Repeat with bne: PCSrc is inverted.
- lw, 0x8C220004: ALUOp=01, ALUSrc=1, MemRead=1, MemWrite=0, MemtoReg=1, RegWrite=1, ALUControl=100000.
- sw, 0xAC220004: ALUSrc=1, MemRead=0, MemWrite=1, RegWrite=0, ALUControl=100000.
- Unsupported opcode 111111: Debug=1, every other control output 0.
- ori, 0x34220005: ALUZero=1, ALUControl=100101.
